// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-locked round-robin arbiter sharing one sync FIFO write port among N_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add per-requester accepted-beat counters (stat_beats, stat_clr).
module fifo_wr_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        fifo_cs,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  input  logic                        fifo_full,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic                        stat_clr,
  output logic [N_REQ*16-1:0]         stat_beats,
`endif
  output logic                        busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, rr_nx, owner, owner_nx, win;
  logic [IW:0] idx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic [TW-1:0] idle_cnt, idle_nx;
  logic own_valid, xfer, rel;
  // scan downward so the lowest offset from rr_ptr is the last (winning) assignment
  always_comb begin
    win = rr_ptr;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (IW+1)'(k);
      idx = (idx >= (IW+1)'(N_REQ)) ? idx - (IW+1)'(N_REQ) : idx;
      win = req_valid[idx[IW-1:0]] ? idx[IW-1:0] : win;
    end
  end
  always_comb begin
    busy       = state == BURST;
    own_valid  = req_valid[owner];
    xfer       = busy & own_valid & ~fifo_full;
    rel        = busy & (xfer ? (req_last[owner] | (beat_cnt == BW'(MAX_BURST - 1)))
                              : (~own_valid & (idle_cnt == TW'(IDLE_TIMEOUT - 1))));
    req_ready  = xfer ? {{(N_REQ-1){1'b0}}, 1'b1} << owner : '0;
    fifo_cs    = xfer;
    fifo_wr_en = xfer;
    grant_id   = owner;
    state_nx   = busy ? (rel ? IDLE : BURST) : (|req_valid ? BURST : IDLE);
    owner_nx   = (busy | ~|req_valid) ? owner : win;
    rr_nx      = rel ? ((owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1) : rr_ptr;
    beat_nx    = busy ? beat_cnt + BW'(xfer) : '0;
    idle_nx    = (busy & ~own_valid) ? idle_cnt + 1'b1 : '0;
  end
  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++)
      fifo_data = (busy && owner == IW'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : fifo_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_nx;
      owner    <= owner_nx;
      beat_cnt <= beat_nx;
      idle_cnt <= idle_nx;
    end
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] cnt [N_REQ];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (stat_clr) cnt[i] <= '0;
        else if (xfer && owner == IW'(i) && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 1'b1;
    end
  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_beats[g*16 +: 16] = cnt[g];
  end
`endif
endmodule
